// File: rtl/ln_interp_ctrl.sv
// ln(x) sequencer: normalizes an unsigned Q16.16 operand, reads two ln ROM entries and interpolates.
// Define LN_INTERP_ROUND_EN to round the interpolation term half-up instead of flooring it.
module ln_interp_ctrl #(
    parameter logic signed [15:0] LN2_Q   = 16'sd710,
    parameter logic signed [15:0] ERR_VAL = 16'sh8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    output logic [9:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_ln,
    output logic        out_err
);

    typedef enum logic [2:0] {
        StIdle,
        StNorm,
        StRd0,
        StRd1,
        StCalc,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        x_q, x_d;
    logic signed [5:0]  exp_q, exp_d;
    logic [8:0]         idx_q, idx_d;
    logic [9:0]         frac_q, frac_d;
    logic signed [15:0] y0_q, y0_d;
    logic signed [15:0] y1_q, y1_d;
    logic [9:0]         rom_addr_q, rom_addr_d;
    logic [15:0]        out_ln_q, out_ln_d;
    logic               out_err_q, out_err_d;

    logic [4:0]         lead_pos;
    logic [4:0]         shift_amt;
    logic [31:0]        mant;
    logic signed [16:0] diff;
    logic signed [27:0] prod;
    logic signed [27:0] interp;
    logic signed [31:0] ln_sum;
    logic               unused_bits;

    always_comb begin
        lead_pos = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (x_q[i]) begin
                lead_pos = 5'(i);
            end
        end
        shift_amt = 5'd31 - lead_pos;
        mant      = x_q << shift_amt;
    end

    always_comb begin
        diff = {y1_q[15], y1_q} - {y0_q[15], y0_q};
        prod = 28'(diff) * 28'($signed({1'b0, frac_q}));
`ifdef LN_INTERP_ROUND_EN
        interp = (prod + 28'sd512) >>> 10;
`else
        interp = prod >>> 10;
`endif
        // Exponent term is at most 11360 in magnitude, so the 16-bit result never wraps.
        ln_sum = 32'(exp_q) * 32'(LN2_Q) + 32'(y0_q) + 32'(interp);
    end

    assign unused_bits = ^{mant[31], mant[11:0], ln_sum[31:16]};

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        exp_d      = exp_q;
        idx_d      = idx_q;
        frac_d     = frac_q;
        y0_d       = y0_q;
        y1_d       = y1_q;
        rom_addr_d = rom_addr_q;
        out_ln_d   = out_ln_q;
        out_err_d  = out_err_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d     = in_x;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (x_q == 32'd0) begin
                    out_ln_d  = ERR_VAL;
                    out_err_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    exp_d      = $signed({1'b0, lead_pos}) - 6'sd16;
                    idx_d      = mant[30:22];
                    frac_d     = mant[21:12];
                    rom_addr_d = {1'b0, mant[30:22]};
                    state_d    = StRd0;
                end
            end
            StRd0: begin
                y0_d       = rom_data;
                rom_addr_d = {1'b0, idx_q} + 10'd1;
                state_d    = StRd1;
            end
            StRd1: begin
                y1_d    = rom_data;
                state_d = StCalc;
            end
            StCalc: begin
                out_ln_d  = ln_sum[15:0];
                out_err_d = 1'b0;
                state_d   = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            x_q        <= '0;
            exp_q      <= '0;
            idx_q      <= '0;
            frac_q     <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            rom_addr_q <= '0;
            out_ln_q   <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            exp_q      <= exp_d;
            idx_q      <= idx_d;
            frac_q     <= frac_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
            rom_addr_q <= rom_addr_d;
            out_ln_q   <= out_ln_d;
            out_err_q  <= out_err_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign rom_addr  = rom_addr_q;
    assign out_ln    = out_ln_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_ln_interp_ctrl.sv
// Scoreboard bench for ln_interp_ctrl with a behavioural ln ROM and an integer golden model.
module tb_ln_interp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ln;
    logic        out_err;

    logic signed [15:0] rom [0:512];
    logic [16:0]        sb_q[$];
    int                 n_checks = 0;
    int                 n_fail = 0;
    logic [15:0]        last_ln;
    logic               last_err;

    always #5 clk = ~clk;

    assign rom_data = (rom_addr <= 10'd512) ? rom[rom_addr] : 16'h0000;

    ln_interp_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ln   (out_ln),
        .out_err  (out_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Golden model: {err, ln} plus the first ROM index it expects to be read.
    function automatic logic [16:0] model_ln(input logic [31:0] x, output int idx_o);
        int p, frac, y0, y1, prod, term, res;
        logic [19:0] mnt;
        idx_o = 0;
        if (x == 32'd0) return {1'b1, 16'h8000};
        p = 0;
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) begin
                p = i;
                break;
            end
        end
        if (p >= 19) mnt = 20'(x >> (p - 19));
        else         mnt = 20'(x << (19 - p));
        idx_o = int'(mnt[18:10]);
        frac  = int'(mnt[9:0]);
        y0    = rom[idx_o];
        y1    = rom[idx_o + 1];
        prod  = (y1 - y0) * frac;
`ifdef LN_INTERP_ROUND_EN
        term = (prod + 512) >>> 10;
`else
        term = prod >>> 10;
`endif
        res = (p - 16) * 710 + y0 + term;
        return {1'b0, res[15:0]};
    endfunction

    task automatic run_op(input logic [31:0] x, input int hold);
        logic [9:0]  addr_prev;
        logic [9:0]  addr_c [0:7];
        logic [16:0] exp;
        logic [15:0] ln0;
        logic        err0;
        int          idx;
        int          cyc;
        int          guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        check_eq("in_ready_before_op", {31'd0, in_ready}, 32'd1);
        addr_prev = rom_addr;
        for (int i = 0; i < 8; i++) addr_c[i] = 10'h3ff;
        in_x     = x;
        in_valid = 1'b1;
        exp      = model_ln(x, idx);
        sb_q.push_back(exp);
        tick();
        in_valid = 1'b0;
        in_x     = $urandom;
        cyc      = 1;
        while (!out_valid && cyc < 20) begin
            if (cyc < 8) addr_c[cyc] = rom_addr;
            tick();
            cyc++;
        end
        if (!out_valid) begin
            check_eq("out_valid_timeout", {31'd0, out_valid}, 32'd1);
            void'(sb_q.pop_front());
            return;
        end
        check_eq("latency", cyc, (x == 32'd0) ? 32'd2 : 32'd5);
        if (x != 32'd0) begin
            check_eq("rom_addr_first", {22'd0, addr_c[2]}, idx);
            check_eq("rom_addr_second", {22'd0, addr_c[3]}, idx + 1);
        end else begin
            check_eq("rom_addr_unchanged", {22'd0, rom_addr}, {22'd0, addr_prev});
        end
        ln0  = out_ln;
        err0 = out_err;
        repeat (hold) begin
            in_valid = 1'b1;
            in_x     = 32'h0003_0000;
            tick();
            check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
            check_eq("hold_ln", {16'd0, out_ln}, {16'd0, ln0});
            check_eq("hold_err", {31'd0, out_err}, {31'd0, err0});
            check_eq("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp       = sb_q.pop_front();
        check_eq("out_ln", {16'd0, out_ln}, {16'd0, exp[15:0]});
        check_eq("out_err", {31'd0, out_err}, {31'd0, exp[16]});
        last_ln  = out_ln;
        last_err = out_err;
        tick();
        out_ready = 1'b0;
        check_eq("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
        check_eq("valid_drop_after_hs", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i <= 512; i++) begin
            rom[i] = 16'($rtoi($ln(1.0 + i / 512.0) * 1024.0 + 0.5));
        end
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_x      = 32'd0;
        tick();
        tick();
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_ln", {16'd0, out_ln}, 32'd0);
        check_eq("rst_out_err", {31'd0, out_err}, 32'd0);
        check_eq("rst_rom_addr", {22'd0, rom_addr}, 32'd0);
        rst = 1'b0;
        tick();

        run_op(32'h0001_0000, 0);
        check_eq("ln_1p0", {16'd0, last_ln}, 32'h0000);
        run_op(32'h0002_0000, 0);
        check_eq("ln_2p0", {16'd0, last_ln}, 32'h02C6);
        run_op(32'h0000_0001, 1);
        check_eq("ln_min", {16'd0, last_ln}, 32'hD3A0);
        run_op(32'h0001_8000, 0);
        check_eq("ln_1p5", {16'd0, last_ln}, 32'h019F);
        run_op(32'h0001_0040, 0);
        run_op(32'h0000_0000, 3);
        check_eq("ln_zero", {16'd0, last_ln}, 32'h8000);
        check_eq("err_zero", {31'd0, last_err}, 32'd1);
        run_op(32'h0005_4321, 10);
        run_op(32'hFFFF_FFFF, 0);
        run_op(32'h8000_0000, 0);
        run_op(32'h0001_FFFF, 0);
        for (int k = 0; k < 8; k++) begin
            run_op($urandom >> $urandom_range(0, 31), $urandom_range(0, 2));
        end

        // Abort an operation while it sits in RD1.
        in_x     = 32'h0001_8000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check_eq("abort_rom_addr_rd1", {22'd0, rom_addr}, 32'd257);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("abort_rom_addr", {22'd0, rom_addr}, 32'd0);
        check_eq("abort_out_ln", {16'd0, out_ln}, 32'd0);
        repeat (8) begin
            tick();
            check_eq("abort_no_output", {31'd0, out_valid}, 32'd0);
        end
        run_op(32'h0003_0000, 0);
        check_eq("sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ln_interp_ctrl.md
# ln_interp_ctrl

Sequencer that evaluates ln(x) for the Black-Scholes datapath using the shared 513-entry ln lookup ROM (Q6.10, ln over [1,2)).
- Normalizes an unsigned Q16.16 operand to exponent plus mantissa.
- Drives two consecutive ROM reads (idx, idx+1) through the ROM's single address port.
- Linearly interpolates between the two entries and adds exponent·ln2.
- Sits between the d1/d2 pre-processing stage and the downstream divide/accumulate stage, with valid/ready handshakes on both sides.

## Interface
Parameters:
- LN2_Q: 16'sd710. ln2 in Q6.10.
- ERR_VAL: 16'sh8000. Result driven for x = 0.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block idle, can accept.
- in_x  in  32  unsigned Q16.16 operand.
- rom_addr  out  10  ROM address, driven from a register.
- rom_data  in  16  ROM word, signed Q6.10, combinational from rom_addr.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_ln  out  16  signed Q6.10 ln(x).
- out_err  out  1  x was 0.

## Operation
States: IDLE, NORM, RD0, RD1, CALC, DONE.

- **IDLE**
  - in_ready = 1.
  - On in_valid: capture in_x, go to NORM.
- **NORM**
  - If x = 0: out_ln = ERR_VAL, out_err = 1, go to DONE.
  - Otherwise, find the leading-one position p (0..31) and compute:
    - e = p − 16, signed 6-bit, range −16..15.
    - m = x << (31 − p).
    - idx = m[30:22].
    - frac = m[21:12], unsigned 10-bit.
  - Register e, idx and frac; set rom_addr = {1'b0, idx}; go to RD0.
- **RD0**
  - Capture y0 = rom_data.
  - Set rom_addr = idx + 1 (max 512); go to RD1.
- **RD1**
  - Capture y1 = rom_data; go to CALC.
- **CALC**
  - d = y1 − y0 (17-bit signed).
  - prod = d · frac (27-bit signed).
  - out_ln = e·LN2_Q + y0 + (prod >>> 10).
  - The sum fits in 16 bits with no saturation (|e·LN2_Q| ≤ 11360).
  - out_err = 0; go to DONE.
- **DONE**
  - out_valid = 1; out_ln and out_err held stable.
  - On out_ready: go to IDLE.

General rules:
- Only one operation is in flight; in_ready = 0 outside IDLE.
- in_x is ignored while in_ready = 0.
- out_valid deasserts in the cycle after the handshake; the block can accept a new operand on that same cycle.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_ln 0, out_err 0, rom_addr 0, internal registers 0.
- Reset has priority in every state. It aborts any in-flight operation with no output produced; the block is in IDLE the cycle after rst is sampled.
- Latency (acceptance edge = cycle 0):
  - Nonzero x: out_valid = 1 in cycle 5.
  - x = 0: out_valid = 1 in cycle 2.
- Throughput with out_ready tied high: 1 result per 6 cycles (3 for x = 0).
- rom_addr changes only on clock edges. rom_data is sampled at the end of RD0 and RD1, so the ROM path must settle within one cycle.
- in_valid and out_ready are level-sensitive. If in_valid is asserted while in DONE, it is not accepted until the block returns to IDLE.

## Configuration
- LN_INTERP_ROUND_EN defined: interpolation term = (prod + 512) >>> 10, i.e. round-half-up.
- LN_INTERP_ROUND_EN undefined: interpolation term = prod >>> 10, i.e. floor.
- All other behaviour is identical in both builds.

## Test plan
- x = 0x00010000 (1.0): idx 0, frac 0 -> out_ln 0x0000, out_err 0, out_valid in cycle 5; rom_addr sequence 0 then 1.
- x = 0x00020000 (2.0) -> out_ln 0x02C6. x = 0x00000001 -> out_ln 0xD3A0 (−11360).
- x = 0x00018000 (1.5): rom_addr 256 then 257 -> out_ln = rom[256] (0x019F for the production table).
- x = 0x00010040: frac = 512 -> out_ln = y0 + (d·512 >>> 10) without the macro, y0 + ((d·512 + 512) >>> 10) with LN_INTERP_ROUND_EN. Check both builds against a golden model.
- x = 0 -> out_ln 0x8000, out_err 1, out_valid in cycle 2; no ROM address change.
- Backpressure/reset:
  - Hold out_ready low 10 cycles -> out_valid, out_ln and out_err stable, in_ready 0; in_ready 1 the cycle after the handshake.
  - Assert rst during RD1 -> next cycle IDLE, out_valid 0, rom_addr 0, no stale output.
